axi_lite_master_bridge: RTL and testbench

Single-outstanding AXI-Lite master that converts a simple valid/ready command stream into AXI-Lite read and write transactions. It sits directly upstream of `axi_lite_slave` and drives its five channels from the master side. Completed transactions are returned on a valid/ready response stream. It serves as the stimulus front end in the AXI bench and as a register-access master in system builds.

---
 rtl/axi_lite_master_bridge.sv | 198 +++++++++++++++++++
 tb/tb_axi_lite_master_bridge.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI-Lite master: turns a valid/ready command stream into AXI-Lite
// read/write transactions and returns a response. Optional: AXI_LM_ALIGN_CHECK_EN.
module axi_lite_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  awvalid_q, awvalid_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;

    logic cmd_fire, aw_left, w_left, b_fire, ar_fire, r_fire, rsp_fire, misalign;

    assign cmd_fire = cmd_valid && cmd_ready_q;
    // A write channel stays pending until its own handshake; each drops independently.
    assign aw_left  = awvalid_q && !AWREADY;
    assign w_left   = wvalid_q && !WREADY;
    assign b_fire   = BVALID && bready_q;
    assign ar_fire  = ARREADY && arvalid_q;
    assign r_fire   = RVALID && rready_q;
    assign rsp_fire = rsp_ready && rsp_valid_q;

`ifdef AXI_LM_ALIGN_CHECK_EN
    localparam int OFFS = $clog2(DATA_WIDTH / 8);
    assign misalign = |cmd_addr[OFFS-1:0];
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (misalign)       state_d = RSP;
                    else if (cmd_write) state_d = WR_REQ;
                    else                state_d = RD_REQ;
                end
            end
            WR_REQ:  if (!aw_left && !w_left) state_d = WR_RESP;
            WR_RESP: if (b_fire)              state_d = RSP;
            RD_REQ:  if (ar_fire)             state_d = RD_DATA;
            RD_DATA: if (r_fire)              state_d = RSP;
            RSP:     if (rsp_fire)            state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Output registers are loaded from the next state so every output is a flop.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        bready_d    = (state_d == WR_RESP);
        arvalid_d   = (state_d == RD_REQ);
        rready_d    = (state_d == RD_DATA);
        rsp_valid_d = (state_d == RSP);
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    rsp_write_d = cmd_write;
                    if (misalign) begin
                        rsp_resp_d  = 2'b10;
                        rsp_rdata_d = '0;
                    end else if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        araddr_d = cmd_addr;
                    end
                end
            end
            WR_REQ: begin
                awvalid_d = aw_left;
                wvalid_d  = w_left;
            end
            WR_RESP: begin
                if (b_fire) begin
                    rsp_resp_d  = BRESP;
                    rsp_rdata_d = '0;
                end
            end
            RD_DATA: begin
                if (r_fire) begin
                    rsp_resp_d  = RRESP;
                    rsp_rdata_d = RDATA;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = cmd_ready_q;
    assign AWADDR    = awaddr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = araddr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: vector table driven through a delay-programmable AXI-Lite
// slave model, responses checked against a scoreboard queue, plus reset/spurious-response sequences.
module tb_axi_lite_master_bridge;

`ifdef AXI_LM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        ACLK, ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr, wdata;
        int          aw_d, w_d, b_d, ar_d, r_d, rsp_d;
        logic [1:0]  bresp, rresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0, n_errors = 0, cyc = 0;

    // Slave-model configuration and observations
    int          cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    bit          cfg_spur = 1'b0;
    int          aw_first, w_first, ar_first, aw_last, w_last, ar_last;
    logic [31:0] awaddr_seen, wdata_seen, araddr_seen;
    logic [31:0] mem [logic [31:0]];

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // AXI-Lite slave model: all decisions on the falling edge, handshakes inferred from
    // the VALID/READY pair seen on the previous falling edge.
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_done, w_done, ar_done, aw_fire, w_fire, b_fire, ar_fire, r_fire;
    bit          aw_hold, w_hold, ar_hold;
    logic [31:0] aw_hold_a, w_hold_d, ar_hold_a;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_done = 0; w_done = 0; ar_done = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_hold = 0; w_hold = 0; ar_hold = 0;
        end else if (cfg_spur) begin
            BVALID = 1; RVALID = 1; BRESP = 2'b11; RRESP = 2'b11; RDATA = 32'h5A5A_5A5A;
            AWREADY = 0; WREADY = 0; ARREADY = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        end else begin
            if (aw_fire) aw_done = 1;
            if (w_fire) begin w_done = 1; mem[awaddr_seen] = wdata_seen; end
            if (ar_fire) ar_done = 1;
            if (b_fire) begin aw_done = 0; w_done = 0; end
            if (r_fire) ar_done = 0;
            if (!(aw_done && w_done)) begin BVALID = 0; b_cnt = 0; end
            if (!ar_done) begin RVALID = 0; r_cnt = 0; end

            if (AWVALID) begin
                if (aw_done) check("aw_reasserted", AWVALID, 0);
                if (aw_hold) check("awaddr_stable", AWADDR, aw_hold_a);
                else begin aw_first = cyc; awaddr_seen = AWADDR; end
                aw_last = cyc;
                AWREADY = (aw_cnt >= cfg_aw_d); aw_cnt++;
            end else begin AWREADY = 0; aw_cnt = 0; end
            aw_hold = AWVALID && !AWREADY; aw_hold_a = AWADDR; aw_fire = AWVALID && AWREADY;

            if (WVALID) begin
                if (w_done) check("w_reasserted", WVALID, 0);
                if (w_hold) check("wdata_stable", WDATA, w_hold_d);
                else begin w_first = cyc; wdata_seen = WDATA; end
                w_last = cyc;
                WREADY = (w_cnt >= cfg_w_d); w_cnt++;
            end else begin WREADY = 0; w_cnt = 0; end
            w_hold = WVALID && !WREADY; w_hold_d = WDATA; w_fire = WVALID && WREADY;

            if (aw_done && w_done && !BVALID) begin
                if (b_cnt >= cfg_b_d) begin BVALID = 1; BRESP = cfg_bresp; end
                else b_cnt++;
            end
            if (BREADY) check("bready_after_aw_w", aw_done && w_done, 1);
            b_fire = BVALID && BREADY;

            if (ARVALID) begin
                if (ar_done) check("ar_reasserted", ARVALID, 0);
                if (ar_hold) check("araddr_stable", ARADDR, ar_hold_a);
                else begin ar_first = cyc; araddr_seen = ARADDR; end
                ar_last = cyc;
                ARREADY = (ar_cnt >= cfg_ar_d); ar_cnt++;
            end else begin ARREADY = 0; ar_cnt = 0; end
            ar_hold = ARVALID && !ARREADY; ar_hold_a = ARADDR; ar_fire = ARVALID && ARREADY;

            if (ar_done && !RVALID) begin
                if (r_cnt >= cfg_r_d) begin
                    RVALID = 1; RRESP = cfg_rresp;
                    RDATA = mem.exists(araddr_seen) ? mem[araddr_seen] : ~araddr_seen;
                end else r_cnt++;
            end
            if (RREADY) check("rready_after_ar", ar_done, 1);
            r_fire = RVALID && RREADY;
        end
    end

    function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata,
                                int aw_d, int w_d, int b_d, int ar_d, int r_d, int rsp_d,
                                logic [1:0] bresp, logic [1:0] rresp,
                                logic [31:0] exp_rdata, logic [1:0] exp_resp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.ar_d = ar_d; v.r_d = r_d; v.rsp_d = rsp_d;
        v.bresp = bresp; v.rresp = rresp; v.exp_rdata = exp_rdata; v.exp_resp = exp_resp;
        return v;
    endfunction

    // Called on a falling edge with the bridge idle; returns on a falling edge.
    task automatic run_txn(input vec_t v, input int idx);
        exp_t        e, got;
        int          c0, t;
        bit          misal;
        logic [31:0] s_rdata;
        logic        s_wr;
        logic [1:0]  s_resp;
        string       p;
        p = $sformatf("v%0d_", idx);
        misal = ALIGN_EN && (v.addr[1:0] != 2'b00);
        cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d;
        cfg_ar_d = v.ar_d; cfg_r_d = v.r_d; cfg_bresp = v.bresp; cfg_rresp = v.rresp;
        aw_first = -1; w_first = -1; ar_first = -1;
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge ACLK); t++; end
        check({p, "cmd_accept"}, cmd_ready, 1);
        c0 = cyc;
        e.wr    = v.wr;
        e.rdata = misal ? 32'h0 : v.exp_rdata;
        e.resp  = misal ? 2'b10 : v.exp_resp;
        e.lat   = misal ? 1 : 3 + (v.wr ? ((v.aw_d > v.w_d ? v.aw_d : v.w_d) + v.b_d)
                                        : (v.ar_d + v.r_d));
        sb.push_back(e);
        @(negedge ACLK);
        cmd_valid = 0;
        t = 0;
        while (!rsp_valid && t < 300) begin @(negedge ACLK); t++; end
        check({p, "rsp_latency"}, 64'(cyc - c0), 64'(e.lat));
        check({p, "cmd_ready_busy"}, cmd_ready, 0);
        s_wr = rsp_write; s_rdata = rsp_rdata; s_resp = rsp_resp;
        for (int k = 0; k < v.rsp_d; k++) begin
            @(negedge ACLK);
            check({p, "rsp_stable"}, {rsp_valid, rsp_write, rsp_rdata, rsp_resp},
                  {1'b1, s_wr, s_rdata, s_resp});
            check({p, "cmd_ready_stall"}, cmd_ready, 0);
        end
        rsp_ready = 1;
        got = sb.pop_front();
        check({p, "rsp_write"}, rsp_write, got.wr);
        check({p, "rsp_rdata"}, rsp_rdata, got.rdata);
        check({p, "rsp_resp"}, rsp_resp, got.resp);
        @(negedge ACLK);
        rsp_ready = 0;
        check({p, "rsp_drop"}, rsp_valid, 0);
        check({p, "cmd_ready_back"}, cmd_ready, 1);
        if (misal) begin
            check({p, "no_aw"}, 64'(aw_first), 64'(-1));
            check({p, "no_ar"}, 64'(ar_first), 64'(-1));
        end else if (v.wr) begin
            check({p, "aw_first"}, 64'(aw_first), 64'(c0 + 1));
            check({p, "w_first"}, 64'(w_first), 64'(c0 + 1));
            check({p, "aw_last"}, 64'(aw_last), 64'(c0 + 1 + v.aw_d));
            check({p, "w_last"}, 64'(w_last), 64'(c0 + 1 + v.w_d));
            check({p, "awaddr"}, awaddr_seen, v.addr);
            check({p, "wdata"}, wdata_seen, v.wdata);
            check({p, "no_ar"}, 64'(ar_first), 64'(-1));
        end else begin
            check({p, "ar_first"}, 64'(ar_first), 64'(c0 + 1));
            check({p, "ar_last"}, 64'(ar_last), 64'(c0 + 1 + v.ar_d));
            check({p, "araddr"}, araddr_seen, v.addr);
            check({p, "no_aw"}, 64'(aw_first), 64'(-1));
        end
    endtask

    vec_t vecs[11];

    initial begin
        int t;
        ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0; RVALID = 0;
        RDATA = 0; RRESP = 0;

        //            wr  addr          wdata         aw w  b  ar r  rsp bresp  rresp  exp_rdata     exp_resp
        vecs[0]  = mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 32'h0,         2'b00);
        vecs[1]  = mk(0, 32'h0000_0010, 32'h0,         0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 32'hDEAD_BEEF, 2'b00);
        vecs[2]  = mk(1, 32'h0000_0020, 32'h1234_5678, 0, 5, 0, 0, 0,  0, 2'b00, 2'b00, 32'h0,         2'b00);
        vecs[3]  = mk(1, 32'h0000_0024, 32'hCAFE_F00D, 4, 0, 2, 0, 0,  0, 2'b10, 2'b00, 32'h0,         2'b10);
        vecs[4]  = mk(0, 32'h0000_0020, 32'h0,         0, 0, 0, 0, 10, 0, 2'b00, 2'b10, 32'h1234_5678, 2'b10);
        vecs[5]  = mk(0, 32'h0000_0024, 32'h0,         0, 0, 0, 3, 0,  0, 2'b00, 2'b11, 32'hCAFE_F00D, 2'b11);
        vecs[6]  = mk(1, 32'h0000_0030, 32'h0BAD_F00D, 0, 0, 0, 0, 0,  3, 2'b11, 2'b00, 32'h0,         2'b11);
        vecs[7]  = mk(0, 32'h0000_0030, 32'h0,         0, 0, 0, 0, 0,  3, 2'b00, 2'b00, 32'h0BAD_F00D, 2'b00);
        vecs[8]  = mk(0, 32'h0000_0040, 32'h0,         0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 32'hFFFF_FFBF, 2'b00);
        vecs[9]  = mk(1, 32'h0000_0013, 32'hAAAA_5555, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 32'h0,         2'b00);
        vecs[10] = mk(0, 32'h0000_0013, 32'h0,         0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 32'hAAAA_5555, 2'b00);

        repeat (3) @(negedge ACLK);
        check("rst_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}, 0);
        check("rst_aw_w", {AWADDR, WDATA}, 0);
        check("rst_ar_rd", {ARADDR, rsp_rdata}, 0);
        check("rst_rsp", {rsp_write, rsp_resp}, 0);
        ARESETn = 1;
        @(negedge ACLK);
        check("cmd_ready_after_rst", cmd_ready, 1);

        for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

        // Responses presented while idle must be ignored
        cfg_spur = 1;
        repeat (4) begin
            @(negedge ACLK);
            check("spur_ready", {BREADY, RREADY, rsp_valid, cmd_ready}, 4'b0001);
        end
        cfg_spur = 0;
        repeat (2) @(negedge ACLK);

        // Reset while waiting for the write response discards the transaction
        cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 20; cfg_bresp = 2'b00;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'h7777_0000;
        @(negedge ACLK);
        cmd_valid = 0;
        t = 0;
        while (!BREADY && t < 20) begin @(negedge ACLK); t++; end
        check("rstseq_in_wr_resp", BREADY, 1);
        ARESETn = 0;
        @(negedge ACLK);
        check("rstseq_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}, 0);
        check("rstseq_aw_w", {AWADDR, WDATA}, 0);
        check("rstseq_rsp", {rsp_write, rsp_rdata, rsp_resp}, 0);
        @(negedge ACLK);
        ARESETn = 1;
        @(negedge ACLK);
        check("rstseq_cmd_ready", cmd_ready, 1);
        repeat (25) begin
            check("rstseq_no_rsp", rsp_valid, 0);
            @(negedge ACLK);
        end
        cfg_b_d = 0;
        run_txn(vecs[1], 11);
        check("sb_empty", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
